// File: rtl/drac_pkg.sv
// Shared types and helpers for the DRAC L1.5 request path.
package drac_pkg;

   // Request stage handshake state: nothing presented / head held toward L1.5
   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } l15_stage_state_e;

   // A request may issue if it needs no return, or a return credit is free
   function automatic logic l15_credit_ok(input logic        needs_rtrn,
                                          input int unsigned outstanding,
                                          input int unsigned max_outstanding);
      return !needs_rtrn || (outstanding < max_outstanding);
   endfunction

endpackage

// File: rtl/drac_l15_req_fifo.sv
// Request FIFO for the L1.5 request stage: storage, pointers and count only.
// Exposes the head entry and the entry behind it so the owner can look ahead.
module drac_l15_req_fifo #(
   parameter int unsigned Width = 257,
   parameter int unsigned Depth = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [Width-1:0]           wdata_i,
   output logic [Width-1:0]           head_o,
   output logic [Width-1:0]           next_o,
   output logic [$clog2(Depth+1)-1:0] count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth+1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr;
   logic [PtrW-1:0]  rd_ptr;
   logic [PtrW-1:0]  rd_ptr_nxt;
   logic [CntW-1:0]  count;

   // Pointers wrap naturally because Depth is a power of two
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_i) wr_ptr <= wr_ptr + PtrW'(1);
         if (pop_i)  rd_ptr <= rd_ptr + PtrW'(1);
         case ({push_i, pop_i})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage; contents are only meaningful between push and pop
   always_ff @(posedge clk_i) begin
      if (push_i) mem[wr_ptr] <= wdata_i;
   end

   // Head and look-ahead entry for back-to-back issue decisions
   always_comb begin
      rd_ptr_nxt = rd_ptr + PtrW'(1);
      head_o     = mem[rd_ptr];
      next_o     = mem[rd_ptr_nxt];
      count_o    = count;
   end

endmodule

// File: rtl/drac_l15_req_stage.sv
// Request staging buffer between the HPDC/I$ adapter and the L1.5 request port.
// Queues requests, presents the head with hold-until-ack, enforces a return
// credit budget and reports idle/drain status to the tile.
module drac_l15_req_stage
   import drac_pkg::*;
#(
   parameter int unsigned ReqWidth       = 256,
   parameter int unsigned Depth          = 4,
   parameter int unsigned MaxOutstanding = 8
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                in_valid_i,
   output logic                                in_ready_o,
   input  logic [ReqWidth-1:0]                 in_req_i,
   input  logic                                in_needs_rtrn_i,
   output logic                                l15_val_o,
   output logic [ReqWidth-1:0]                 l15_req_o,
   input  logic                                l15_header_ack_i,
   input  logic                                rtrn_done_i,
   input  logic                                drain_i,
   output logic                                idle_o,
   output logic [$clog2(Depth+1)-1:0]          occupancy_o,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
   output logic                                credit_err_o
);

   localparam int unsigned CntW = $clog2(Depth+1);
   localparam int unsigned OutW = $clog2(MaxOutstanding+1);
   localparam int unsigned EntW = ReqWidth + 1;

   l15_stage_state_e  state;
   l15_stage_state_e  state_next;
   logic [OutW-1:0]   outstanding;
   logic [OutW-1:0]   outstanding_next;
   logic              credit_err;

   logic [EntW-1:0]   head_ent;
   logic [EntW-1:0]   next_ent;
   logic [CntW-1:0]   count;
   logic              head_needs;
   logic              next_needs;
   logic              push;
   logic              pop;
   logic              rtrn_inc;
   logic              rtrn_dec;
   logic              cand_valid;
   logic              cand_needs;

   drac_l15_req_fifo #(
      .Width (EntW),
      .Depth (Depth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({in_needs_rtrn_i, in_req_i}),
      .head_o  (head_ent),
      .next_o  (next_ent),
      .count_o (count)
   );

   // Handshake qualifiers and credit arithmetic for this cycle
   always_comb begin
      in_ready_o       = !rst_i && (count < CntW'(Depth)) && !drain_i;
      push             = in_valid_i && in_ready_o;
      pop              = (state == PRESENT) && l15_header_ack_i;
      head_needs       = head_ent[ReqWidth];
      next_needs       = next_ent[ReqWidth];
      rtrn_inc         = pop && head_needs;
      rtrn_dec         = rtrn_done_i && (outstanding != '0);
      outstanding_next = outstanding + OutW'(rtrn_inc) - OutW'(rtrn_dec);
   end

   // Next-state: present the next candidate only if it passes the credit check
   // against the counters as they will be after this edge
   always_comb begin
      state_next = state;
      cand_valid = 1'b0;
      cand_needs = 1'b0;
      unique case (state)
         IDLE: begin
            if (count != '0) begin
               cand_valid = 1'b1;
               cand_needs = head_needs;
            end else if (push) begin
               cand_valid = 1'b1;
               cand_needs = in_needs_rtrn_i;
            end
            if (cand_valid &&
                l15_credit_ok(cand_needs, 32'(outstanding_next), MaxOutstanding)) begin
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (pop) begin
               if (count > CntW'(1)) begin
                  cand_valid = 1'b1;
                  cand_needs = next_needs;
               end else if (push) begin
                  cand_valid = 1'b1;
                  cand_needs = in_needs_rtrn_i;
               end
               if (cand_valid &&
                   l15_credit_ok(cand_needs, 32'(outstanding_next), MaxOutstanding)) begin
                  state_next = PRESENT;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   // Return credit counter and sticky underflow flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         outstanding <= '0;
         credit_err  <= 1'b0;
      end else begin
         outstanding <= outstanding_next;
         if (rtrn_done_i && (outstanding == '0)) credit_err <= 1'b1;
      end
   end

   // Status and L1.5-facing outputs, all taken from registered state
   always_comb begin
      l15_val_o     = (state == PRESENT);
      l15_req_o     = head_ent[ReqWidth-1:0];
      occupancy_o   = count;
      outstanding_o = outstanding;
      credit_err_o  = credit_err;
      idle_o        = (count == '0) && (state == IDLE) && (outstanding == '0);
   end

endmodule

// File: tb/tb_drac_l15_req_stage.sv
// Self-checking bench for drac_l15_req_stage: directed stimulus, scoreboard of
// expected issue order checked by a separate monitor at each L1.5 handshake.
module tb_drac_l15_req_stage;

   localparam int unsigned RW   = 64;
   localparam int unsigned DEP  = 4;
   localparam int unsigned MAXO = 4;

   logic                          clk_i;
   logic                          rst_i;
   logic                          in_valid_i;
   logic                          in_ready_o;
   logic [RW-1:0]                 in_req_i;
   logic                          in_needs_rtrn_i;
   logic                          l15_val_o;
   logic [RW-1:0]                 l15_req_o;
   logic                          l15_header_ack_i;
   logic                          rtrn_done_i;
   logic                          drain_i;
   logic                          idle_o;
   logic [$clog2(DEP+1)-1:0]      occupancy_o;
   logic [$clog2(MAXO+1)-1:0]     outstanding_o;
   logic                          credit_err_o;

   logic [RW-1:0] exp_q [$];
   logic [RW-1:0] mon_exp;
   int            n_vec;
   int            n_err;

   drac_l15_req_stage #(
      .ReqWidth       (RW),
      .Depth          (DEP),
      .MaxOutstanding (MAXO)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .in_valid_i       (in_valid_i),
      .in_ready_o       (in_ready_o),
      .in_req_i         (in_req_i),
      .in_needs_rtrn_i  (in_needs_rtrn_i),
      .l15_val_o        (l15_val_o),
      .l15_req_o        (l15_req_o),
      .l15_header_ack_i (l15_header_ack_i),
      .rtrn_done_i      (rtrn_done_i),
      .drain_i          (drain_i),
      .idle_o           (idle_o),
      .occupancy_o      (occupancy_o),
      .outstanding_o    (outstanding_o),
      .credit_err_o     (credit_err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_req(input logic [RW-1:0] req, input logic needs, input bit will_issue);
      in_valid_i      = 1'b1;
      in_req_i        = req;
      in_needs_rtrn_i = needs;
      if (will_issue) exp_q.push_back(req);
      step();
      in_valid_i      = 1'b0;
   endtask

   // Monitor: every accepted L1.5 request must match the next expected payload
   always @(negedge clk_i) begin
      if (!rst_i && l15_val_o && l15_header_ack_i) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL issue_unexpected: got %0h, expected none", l15_req_o);
         end else begin
            mon_exp = exp_q.pop_front();
            if (l15_req_o !== mon_exp) begin
               n_err++;
               $display("FAIL issue_payload: got %0h, expected %0h", l15_req_o, mon_exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      n_vec            = 0;
      n_err            = 0;
      rst_i            = 1'b0;
      in_valid_i       = 1'b0;
      in_req_i         = '0;
      in_needs_rtrn_i  = 1'b0;
      l15_header_ack_i = 1'b0;
      rtrn_done_i      = 1'b0;
      drain_i          = 1'b0;
      #2 rst_i = 1'b1;
      #1;
      check("rst_val",     64'(l15_val_o),     64'd0);
      check("rst_ready",   64'(in_ready_o),    64'd0);
      check("rst_idle",    64'(idle_o),        64'd1);
      check("rst_occ",     64'(occupancy_o),   64'd0);
      check("rst_outst",   64'(outstanding_o), 64'd0);
      check("rst_err",     64'(credit_err_o),  64'd0);
      step();
      step();
      rst_i = 1'b0;
      #1;
      check("ready_after_rst", 64'(in_ready_o), 64'd1);

      // Single store with ack tied high: one-cycle presentation, no credit use
      l15_header_ack_i = 1'b1;
      push_req(64'hA000_0000_0000_0001, 1'b0, 1'b1);
      check("t1_val_on",  64'(l15_val_o),     64'd1);
      check("t1_occ",     64'(occupancy_o),   64'd1);
      step();
      check("t1_val_off", 64'(l15_val_o),     64'd0);
      check("t1_outst",   64'(outstanding_o), 64'd0);
      check("t1_idle",    64'(idle_o),        64'd1);
      l15_header_ack_i = 1'b0;

      // Four loads held without ack: payload stable, full stage refuses input
      for (int i = 0; i < 4; i++) push_req(64'hB000_0000_0000_0000 | 64'(i), 1'b1, 1'b1);
      check("t2_ready_full", 64'(in_ready_o),  64'd0);
      check("t2_occ_full",   64'(occupancy_o), 64'd4);
      in_valid_i      = 1'b1;
      in_req_i        = 64'hDEAD_DEAD_DEAD_DEAD;
      in_needs_rtrn_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_hold_req", l15_req_o,       64'hB000_0000_0000_0000);
         check("t2_hold_val", 64'(l15_val_o),  64'd1);
      end
      in_valid_i = 1'b0;
      check("t2_no_push_full", 64'(occupancy_o), 64'd4);
      l15_header_ack_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_b2b_val", 64'(l15_val_o), 64'd1);
      end
      step();
      l15_header_ack_i = 1'b0;
      check("t2_val_end", 64'(l15_val_o),     64'd0);
      check("t2_outst",   64'(outstanding_o), 64'd4);
      check("t2_occ_end", 64'(occupancy_o),   64'd0);

      // Credit budget exhausted: next load waits until a return is consumed
      push_req(64'hC000_0000_0000_0000, 1'b1, 1'b1);
      check("t3_blocked",   64'(l15_val_o),   64'd0);
      check("t3_occ",       64'(occupancy_o), 64'd1);
      step();
      check("t3_blocked2",  64'(l15_val_o),   64'd0);
      rtrn_done_i = 1'b1;
      step();
      rtrn_done_i = 1'b0;
      check("t3_release",   64'(l15_val_o),     64'd1);
      check("t3_outst",     64'(outstanding_o), 64'd3);

      // Ack and return in the same cycle cancel; return at zero is flagged
      rtrn_done_i = 1'b1;
      step();
      step();
      rtrn_done_i = 1'b0;
      check("t4_outst_1", 64'(outstanding_o), 64'd1);
      l15_header_ack_i = 1'b1;
      rtrn_done_i      = 1'b1;
      step();
      l15_header_ack_i = 1'b0;
      rtrn_done_i      = 1'b0;
      check("t4_net_zero", 64'(outstanding_o), 64'd1);
      check("t4_val_off",  64'(l15_val_o),     64'd0);
      rtrn_done_i = 1'b1;
      step();
      rtrn_done_i = 1'b0;
      check("t4_outst_0",  64'(outstanding_o), 64'd0);
      check("t4_err_clr",  64'(credit_err_o),  64'd0);
      rtrn_done_i = 1'b1;
      step();
      rtrn_done_i = 1'b0;
      check("t4_err_set",  64'(credit_err_o),  64'd1);
      check("t4_no_wrap",  64'(outstanding_o), 64'd0);
      step();
      check("t4_err_stky", 64'(credit_err_o),  64'd1);

      // Drain: pushes blocked at once, queued loads still issue, idle after returns
      push_req(64'hE000_0000_0000_0000, 1'b1, 1'b1);
      push_req(64'hE000_0000_0000_0001, 1'b1, 1'b1);
      drain_i = 1'b1;
      #1;
      check("t5_ready_drain", 64'(in_ready_o), 64'd0);
      in_valid_i = 1'b1;
      in_req_i   = 64'hDEAD_BEEF_0000_0000;
      step();
      in_valid_i = 1'b0;
      check("t5_occ",      64'(occupancy_o), 64'd2);
      l15_header_ack_i = 1'b1;
      step();
      check("t5_b2b",      64'(l15_val_o),   64'd1);
      step();
      l15_header_ack_i = 1'b0;
      check("t5_val_off",  64'(l15_val_o),     64'd0);
      check("t5_outst",    64'(outstanding_o), 64'd2);
      check("t5_not_idle", 64'(idle_o),        64'd0);
      rtrn_done_i = 1'b1;
      step();
      check("t5_idle_mid", 64'(idle_o),        64'd0);
      check("t5_outst_1",  64'(outstanding_o), 64'd1);
      step();
      rtrn_done_i = 1'b0;
      check("t5_idle",     64'(idle_o),        64'd1);
      drain_i = 1'b0;

      // Asynchronous reset while presenting with three queued entries
      push_req(64'hF000_0000_0000_0000, 1'b1, 1'b1);
      for (int i = 1; i < 4; i++) push_req(64'hF000_0000_0000_0000 | 64'(i), 1'b1, 1'b0);
      l15_header_ack_i = 1'b1;
      step();
      l15_header_ack_i = 1'b0;
      check("t6_occ_pre",   64'(occupancy_o),   64'd3);
      check("t6_outst_pre", 64'(outstanding_o), 64'd1);
      check("t6_val_pre",   64'(l15_val_o),     64'd1);
      #2 rst_i = 1'b1;
      #1;
      check("t6_val",   64'(l15_val_o),     64'd0);
      check("t6_occ",   64'(occupancy_o),   64'd0);
      check("t6_outst", 64'(outstanding_o), 64'd0);
      check("t6_ready", 64'(in_ready_o),    64'd0);
      check("t6_idle",  64'(idle_o),        64'd1);
      check("t6_err",   64'(credit_err_o),  64'd0);
      step();
      rst_i = 1'b0;
      step();
      check("t6_ready_post", 64'(in_ready_o), 64'd1);
      check("t6_val_post",   64'(l15_val_o),  64'd0);
      check("sb_drained",    64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
